// File: rtl/muldiv32_if.sv
// Issue/result bundle between decode and the muldiv32 unit.
interface muldiv32_if;
  logic [31:0] read_data_1;
  logic [31:0] read_data_2;
  logic [5:0]  Function_opcode;
  logic        Start;
  logic        Busy;
  logic        Done;
  logic        DivZero;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output read_data_1, read_data_2, Function_opcode, Start,
    input  Busy, Done, DivZero, HI, LO
  );

  modport slave (
    input  read_data_1, read_data_2, Function_opcode, Start,
    output Busy, Done, DivZero, HI, LO
  );
endinterface

// File: rtl/muldiv32.sv
// Iterative 32-bit multiply/divide unit owning the architectural HI/LO pair.
// Divide support (DIV/DIVU) is built only when MULDIV_DIV_EN is defined.
module muldiv32 (
  input logic       clock,
  input logic       reset,
  muldiv32_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for an issue
  // RUN   | one radix-2 step per cycle, 32 cycles
  // FIN   | HI/LO valid, Done pulse; may accept the next issue
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [31:0] acc_hi, acc_lo, op_b;
  logic [31:0] hi_q, lo_q;
  logic        neg_q;

  logic        can_issue, go_mul, go_div, go_run, go_mthi, go_mtlo;
  logic        last_iter;
  logic        signed_op, sign_a, sign_b;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [63:0] mul_raw, mul_res;
  logic [31:0] iter_hi, iter_lo, res_hi, res_lo;

  assign can_issue = bus.Start && (state != RUN);
  assign go_mul    = can_issue && ((bus.Function_opcode == F_MULT) ||
                                   (bus.Function_opcode == F_MULTU));
  assign go_mthi   = can_issue && (bus.Function_opcode == F_MTHI);
  assign go_mtlo   = can_issue && (bus.Function_opcode == F_MTLO);
  assign go_run    = go_mul || go_div;
  assign last_iter = (state == RUN) && (cnt == 5'd31);

  // Signed ops run on magnitudes; the sign is restored on the result edge.
  assign signed_op = ~bus.Function_opcode[0];
  assign sign_a    = signed_op & bus.read_data_1[31];
  assign sign_b    = signed_op & bus.read_data_2[31];
  assign mag_a     = sign_a ? (32'd0 - bus.read_data_1) : bus.read_data_1;
  assign mag_b     = sign_b ? (32'd0 - bus.read_data_2) : bus.read_data_2;

  // Shift-add: acc_lo holds the multiplier, low product bits shift in from the top.
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_b} : 33'd0);
  assign mul_raw = {mul_sum, acc_lo[31:1]};
  assign mul_res = neg_q ? (64'd0 - mul_raw) : mul_raw;

`ifdef MULDIV_DIV_EN
  localparam logic [5:0] F_DIV  = 6'b011010;
  localparam logic [5:0] F_DIVU = 6'b011011;

  logic        op_div, neg_r, div_zero;
  logic [32:0] div_shift, div_diff;
  logic [31:0] div_hi, div_lo, rem_fix, quo_fix;

  assign go_div = can_issue && ((bus.Function_opcode == F_DIV) ||
                                (bus.Function_opcode == F_DIVU));

  // Restoring divide: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in.
  assign div_shift = {acc_hi, acc_lo[31]};
  assign div_diff  = div_shift - {1'b0, op_b};
  assign div_hi    = div_diff[32] ? div_shift[31:0] : div_diff[31:0];
  assign div_lo    = {acc_lo[30:0], ~div_diff[32]};
  assign rem_fix   = neg_r ? (32'd0 - div_hi) : div_hi;
  assign quo_fix   = div_zero ? 32'hFFFF_FFFF : (neg_q ? (32'd0 - div_lo) : div_lo);

  always_ff @(posedge clock) begin
    if (reset) begin
      op_div   <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else if (go_run) begin
      op_div   <= go_div;
      neg_r    <= go_div & sign_a;
      div_zero <= go_div && (bus.read_data_2 == 32'd0);
    end
  end

  assign iter_hi     = op_div ? div_hi  : mul_raw[63:32];
  assign iter_lo     = op_div ? div_lo  : mul_raw[31:0];
  assign res_hi      = op_div ? rem_fix : mul_res[63:32];
  assign res_lo      = op_div ? quo_fix : mul_res[31:0];
  assign bus.DivZero = (state == FIN) && div_zero;
`else
  assign go_div      = 1'b0;
  assign iter_hi     = mul_raw[63:32];
  assign iter_lo     = mul_raw[31:0];
  assign res_hi      = mul_res[63:32];
  assign res_lo      = mul_res[31:0];
  assign bus.DivZero = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go_run) state_nxt = RUN;
      RUN:     if (cnt == 5'd31) state_nxt = FIN;
      FIN:     state_nxt = go_run ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt    <= 5'd0;
      acc_hi <= 32'd0;
      acc_lo <= 32'd0;
      op_b   <= 32'd0;
      neg_q  <= 1'b0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
    end else begin
      if (go_run) begin
        cnt    <= 5'd0;
        acc_hi <= 32'd0;
        acc_lo <= mag_a;
        op_b   <= mag_b;
        neg_q  <= sign_a ^ sign_b;
      end else if (state == RUN) begin
        cnt    <= cnt + 5'd1;
        acc_hi <= iter_hi;
        acc_lo <= iter_lo;
      end
      if (last_iter) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
      if (go_mthi) hi_q <= bus.read_data_1;
      if (go_mtlo) lo_q <= bus.read_data_1;
    end
  end

  assign bus.Busy = (state == RUN);
  assign bus.Done = (state == FIN);
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;
endmodule

// File: tb/tb_muldiv32.sv
// Self-checking bench for muldiv32: vector table, random products, handshake corners.
module tb_muldiv32;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_ADD   = 6'b100000;

  typedef struct {
    string       name;
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];
  exp_t exp_q[$];

  muldiv32_if bus();
  muldiv32 dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=no_finish required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic void add_vec(input string name, input logic [5:0] f,
                                  input logic [31:0] a, b, hi, lo, input logic dz);
    vec_t v;
    v.name = name; v.f = f; v.a = a; v.b = b; v.hi = hi; v.lo = lo; v.dz = dz;
    vecs.push_back(v);
  endfunction

  function automatic logic [63:0] mul_model(input logic [5:0] f, input logic [31:0] a, b);
    logic [63:0] xa, xb;
    if (f == F_MULT) begin
      xa = {{32{a[31]}}, a};
      xb = {{32{b[31]}}, b};
    end else begin
      xa = {32'd0, a};
      xb = {32'd0, b};
    end
    return xa * xb;
  endfunction

  function automatic exp_t div_model(input logic [5:0] f, input logic [31:0] a, b);
    exp_t e;
    int   sa, sb;
    e.dz = (b == 32'd0);
    if (b == 32'd0) begin
      e.lo = 32'hFFFF_FFFF;
      e.hi = a;
    end else if (f == F_DIVU) begin
      e.lo = a / b;
      e.hi = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.lo = 32'h8000_0000;
      e.hi = 32'd0;
    end else begin
      sa = a;
      sb = b;
      e.lo = sa / sb;
      e.hi = sa % sb;
    end
    return e;
  endfunction

  // Caller is at a negedge; Start is seen by exactly one rising edge.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, b);
    bus.Function_opcode = f;
    bus.read_data_1     = a;
    bus.read_data_2     = b;
    bus.Start           = 1'b1;
    @(negedge clock);
    bus.Start = 1'b0;
  endtask

  // Returns at the negedge where Done is seen, checked against the scoreboard head.
  task automatic collect(input string name, input int busy_req);
    int   busy_n;
    bit   seen;
    exp_t e;
    busy_n = 0;
    seen   = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.Done === 1'b1) begin
        seen = 1;
        break;
      end
      if (bus.Busy === 1'b1) busy_n++;
      @(negedge clock);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_done_timeout actual=no_done required=done", name);
      if (exp_q.size() > 0) exp_q.delete(0);
      return;
    end
    chk({name, "_busy_cycles"}, 64'(busy_n), 64'(busy_req));
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_unexpected_done actual=done required=empty_scoreboard", name);
      return;
    end
    e = exp_q.pop_front();
    chk({name, "_hi"}, 64'(bus.HI), 64'(e.hi));
    chk({name, "_lo"}, 64'(bus.LO), 64'(e.lo));
    chk({name, "_divzero"}, 64'(bus.DivZero), 64'(e.dz));
  endtask

  task automatic run_op(input string name, input logic [5:0] f,
                        input logic [31:0] a, b, input exp_t e);
    issue(f, a, b);
    exp_q.push_back(e);
    collect(name, 32);
    @(negedge clock);
    chk({name, "_done_pulse"}, 64'(bus.Done), 64'd0);
  endtask

  initial begin
    exp_t        e;
    logic [5:0]  f;
    logic [31:0] a, b;
    logic [63:0] p;
    bit          seen_done;

    add_vec("multu_max",   F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    add_vec("mult_m3x5",   F_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    add_vec("mult_minsq",  F_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
    add_vec("mult_m1xm1",  F_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0);
    add_vec("mult_7xm1",   F_MULT,  32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0);
    add_vec("multu_zero",  F_MULTU, 32'd0,         32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b0);
    add_vec("multu_2p32",  F_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0);
`ifdef MULDIV_DIV_EN
    add_vec("div_m7d2",    F_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    add_vec("divu_7d0",    F_DIVU,  32'd7,         32'd0,         32'h0000_0007, 32'hFFFF_FFFF, 1'b1);
    add_vec("div_ovf",     F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    add_vec("div_7dm2",    F_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    add_vec("div_m7d0",    F_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
    add_vec("divu_100d7",  F_DIVU,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 1'b0);
    add_vec("divu_maxd1",  F_DIVU,  32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 32'hFFFF_FFFF, 1'b0);
`endif

    // Reset for two edges with a competing MTHI on the bus.
    reset               = 1'b1;
    bus.Start           = 1'b1;
    bus.Function_opcode = F_MTHI;
    bus.read_data_1     = 32'hFFFF_FFFF;
    bus.read_data_2     = 32'd0;
    @(negedge clock);
    @(negedge clock);
    chk("reset_hi", 64'(bus.HI), 64'd0);
    chk("reset_lo", 64'(bus.LO), 64'd0);
    chk("reset_busy", 64'(bus.Busy), 64'd0);
    chk("reset_done", 64'(bus.Done), 64'd0);
    chk("reset_divzero", 64'(bus.DivZero), 64'd0);
    reset     = 1'b0;
    bus.Start = 1'b0;
    @(negedge clock);

    for (int i = 0; i < vecs.size(); i++) begin
      e.hi = vecs[i].hi;
      e.lo = vecs[i].lo;
      e.dz = vecs[i].dz;
      run_op(vecs[i].name, vecs[i].f, vecs[i].a, vecs[i].b, e);
    end

    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
`ifdef MULDIV_DIV_EN
      case (i % 4)
        0: f = F_MULT;
        1: f = F_MULTU;
        2: f = F_DIV;
        default: f = F_DIVU;
      endcase
`else
      f = (i % 2 == 0) ? F_MULT : F_MULTU;
`endif
      if (f == F_MULT || f == F_MULTU) begin
        p    = mul_model(f, a, b);
        e.hi = p[63:32];
        e.lo = p[31:0];
        e.dz = 1'b0;
      end else begin
        e = div_model(f, a, b);
      end
      run_op($sformatf("rand%0d", i), f, a, b, e);
    end

    // MTHI/MTLO write directly without a Done pulse.
    issue(F_MTHI, 32'h1234_5678, 32'd0);
    chk("mthi_hi", 64'(bus.HI), 64'h1234_5678);
    chk("mthi_done", 64'(bus.Done), 64'd0);
    chk("mthi_busy", 64'(bus.Busy), 64'd0);
    issue(F_MTLO, 32'hCAFE_BABE, 32'd0);
    chk("mtlo_lo", 64'(bus.LO), 64'hCAFE_BABE);
    chk("mtlo_hi_kept", 64'(bus.HI), 64'h1234_5678);
    chk("mtlo_done", 64'(bus.Done), 64'd0);

    // Unknown funct is ignored.
    issue(F_ADD, 32'h5555_5555, 32'd3);
    chk("unknown_busy", 64'(bus.Busy), 64'd0);
    @(negedge clock);
    chk("unknown_done", 64'(bus.Done), 64'd0);
    chk("unknown_hilo", {bus.HI, bus.LO}, 64'h1234_5678_CAFE_BABE);

    // Issue during RUN (new product and an MTHI) plus operand churn must not disturb the result.
    issue(F_MULTU, 32'h0001_0000, 32'h0003_0000);
    exp_q.push_back('{hi: 32'h0000_0003, lo: 32'h0000_0000, dz: 1'b0});
    repeat (4) @(negedge clock);
    bus.Function_opcode = F_MULTU;
    bus.read_data_1     = 32'd2;
    bus.read_data_2     = 32'd2;
    bus.Start           = 1'b1;
    @(negedge clock);
    bus.Function_opcode = F_MTHI;
    bus.read_data_1     = 32'hDEAD_BEEF;
    @(negedge clock);
    bus.Start       = 1'b0;
    bus.read_data_1 = 32'hFFFF_FFFF;
    bus.read_data_2 = 32'hFFFF_FFFF;
    chk("run_ignore_hi", 64'(bus.HI), 64'h1234_5678);
    chk("run_ignore_busy", 64'(bus.Busy), 64'd1);
    collect("run_ignore", 26);
    @(negedge clock);

    // Back-to-back: issue while in FIN goes straight to RUN.
    issue(F_MULT, 32'hFFFF_FFFD, 32'd5);
    exp_q.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFF1, dz: 1'b0});
    collect("b2b_first", 32);
    issue(F_MULTU, 32'h1234_5678, 32'h0000_0010);
    exp_q.push_back('{hi: 32'h0000_0001, lo: 32'h2345_6780, dz: 1'b0});
    chk("b2b_busy_now", 64'(bus.Busy), 64'd1);
    chk("b2b_done_now", 64'(bus.Done), 64'd0);
    collect("b2b_second", 32);
    @(negedge clock);

    // Abort by reset at RUN cycle 10.
    issue(F_MTHI, 32'hAAAA_0001, 32'd0);
    issue(F_MTLO, 32'hBBBB_0002, 32'd0);
    issue(F_MULTU, 32'd5, 32'd5);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_hi", 64'(bus.HI), 64'd0);
    chk("abort_lo", 64'(bus.LO), 64'd0);
    chk("abort_busy", 64'(bus.Busy), 64'd0);
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.Done === 1'b1 || bus.Busy === 1'b1) seen_done = 1;
      @(negedge clock);
    end
    chk("abort_no_done", 64'(seen_done), 64'd0);
    chk("abort_hilo_kept", {bus.HI, bus.LO}, 64'd0);

`ifndef MULDIV_DIV_EN
    // Without the divide datapath DIV/DIVU are unknown functs.
    issue(F_MTHI, 32'h0000_1111, 32'd0);
    issue(F_MTLO, 32'h0000_2222, 32'd0);
    issue(F_DIV, 32'd7, 32'd2);
    chk("nodiv_busy", 64'(bus.Busy), 64'd0);
    issue(F_DIVU, 32'd7, 32'd0);
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.Done === 1'b1 || bus.Busy === 1'b1 || bus.DivZero === 1'b1) seen_done = 1;
      @(negedge clock);
    end
    chk("nodiv_no_activity", 64'(seen_done), 64'd0);
    chk("nodiv_hilo", {bus.HI, bus.LO}, 64'h0000_1111_0000_2222);
`endif

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv32.md
MULDIV32 -- requirements
Module: muldiv32

Interface
REQ-001 The block SHALL have the port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have the port read_data_1, input, 32 bits: rs operand from decode (multiplicand/dividend, MTHI/MTLO source).
REQ-004 The block SHALL have the port read_data_2, input, 32 bits: rt operand from decode (multiplier/divisor).
REQ-005 The block SHALL have the port Function_opcode, input, 6 bits: R-type funct field.
REQ-006 The block SHALL have the port Start, input, 1 bit: issue strobe, sampled each rising edge.
REQ-007 The block SHALL have the port Busy, output, 1 bit: iterative operation in progress.
REQ-008 The block SHALL have the port Done, output, 1 bit: one-cycle pulse when the HI/LO result is valid.
REQ-009 The block SHALL have the port DivZero, output, 1 bit: qualifies Done; the finished divide had divisor 0.
REQ-010 The block SHALL have the ports HI and LO, outputs, 32 bits each: architectural HI/LO registers.

Function
REQ-011 The block SHALL decode funct as follows: MULT=011000, MULTU=011001, DIV=011010, DIVU=011011, MTHI=010001, MTLO=010011; Start with any other funct SHALL be ignored.
REQ-012 The block SHALL implement states IDLE, RUN and FIN.
REQ-013 The block SHALL accept Start only in IDLE or FIN; Start in RUN SHALL be ignored, with no state, operand or HI/LO change.
REQ-014 On an accepted MTHI/MTLO, the block SHALL load read_data_1 into HI/LO at that edge, without entering RUN and without asserting Done.
REQ-015 On an accepted MULT/MULTU/DIV/DIVU at edge E0, the block SHALL latch the operands, clear a 5-bit iteration counter and enter RUN.
REQ-016 In RUN, the block SHALL perform one radix-2 iteration per edge: shift-add for multiply, restoring subtract for divide.
REQ-017 At edge E32 (counter=31), the block SHALL write HI/LO and enter FIN.
REQ-018 Busy SHALL be 1 exactly in RUN (32 cycles).
REQ-019 Done SHALL be 1 exactly in FIN (1 cycle); FIN SHALL go to RUN on an accepted multi-cycle Start, otherwise to IDLE.
REQ-020 For multiply, {HI,LO} SHALL equal the 64-bit product: two's complement for MULT, unsigned for MULTU.
REQ-021 For divide, LO SHALL be the quotient and HI the remainder; signed quotient truncates toward zero and the remainder takes the dividend's sign.
REQ-022 For DIV 0x80000000 / 0xFFFFFFFF, the block SHALL produce LO=0x80000000 and HI=0.
REQ-023 For a divisor of 0 (DIV or DIVU), the block SHALL produce LO=0xFFFFFFFF, HI=dividend and DivZero=1 during FIN.
REQ-024 DivZero SHALL be 0 in every cycle other than a divide-by-zero FIN.
REQ-025 HI/LO SHALL change only at the E32 result edge, on MTHI/MTLO, or on reset.
REQ-026 Operand inputs SHALL be ignored after E0; changes during RUN SHALL not affect the result.

Reset
REQ-027 When reset=1 at a rising edge, the block SHALL set HI=0, LO=0, state IDLE, counter 0, Busy=0, Done=0 and DivZero=0, overriding Start.
REQ-028 A reset during RUN or FIN SHALL abort the operation with no partial result written and no Done.

Configuration
REQ-029 With macro MULDIV_DIV_EN defined, the block SHALL support DIV/DIVU as specified above.
REQ-030 With MULDIV_DIV_EN undefined, the block SHALL omit the divide datapath, treat DIV/DIVU as unknown funct (ignored: no Busy, no Done, HI/LO unchanged) and tie DivZero to 0.

Verification
REQ-031 Reset: assert reset 2 cycles -> HI=0, LO=0, Busy=0, Done=0, DivZero=0.
REQ-032 MULTU: 0xFFFFFFFF x 0xFFFFFFFF -> Busy for 32 cycles, then Done for 1 cycle with HI=0xFFFFFFFE, LO=0x00000001.
REQ-033 MULT: -3 x 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; MULT 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0.
REQ-034 Divide (MULDIV_DIV_EN defined): DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 -> LO=0xFFFFFFFF, HI=7, DivZero=1 with Done.
REQ-035 Handshake: MTHI 0x12345678 in IDLE -> HI=0x12345678 next cycle, Done stays 0; MULTU then Start with new operands at RUN cycle 5 -> ignored, original product returned; Start in FIN -> back-to-back RUN with no IDLE cycle.
REQ-036 Abort: reset at RUN cycle 10 -> IDLE, HI=LO=0, no Done pulse; with MULDIV_DIV_EN undefined, a DIV Start -> Busy stays 0 and HI/LO are unchanged.
